// File: rtl/redirect_controller.sv
// Control-flow redirect sequencer for the RV32I pipeline: captures an EX-stage jump,
// waits out stalls, strobes a PC load with flushes, then drains wrong-path requests.
module redirect_controller #(
   parameter int PC_W      = 9,
   parameter int DRAIN_CYC = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             jump_valid,
   input  logic [31:0]      jump_target,
   input  logic             stall,
   output logic             pc_load,
   output logic [PC_W-1:0]  pc_target,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             busy,
   output logic             misaligned_trap,
   output logic [CNT_W-1:0] redirect_count
);

   typedef enum logic [1:0] {IDLE, HOLD, ISSUE, DRAIN} state_t;

   state_t           state_reg, state_next;
   logic [2:0]       drain_reg, drain_next;
   logic [PC_W-1:0]  target_reg, target_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             trap_next;
   logic             pc_load_reg, flush_if_id_reg, flush_id_ex_reg, busy_reg, trap_reg;

   // Bits above PC_W are dropped on purpose; the low two bits feed the alignment check.
   logic unused_target_bits;
   assign unused_target_bits = ^jump_target;

   always_comb begin
      state_next  = state_reg;
      drain_next  = drain_reg;
      target_next = target_reg;
      count_next  = count_reg;
      trap_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (jump_valid) begin
               if (jump_target[1:0] != 2'b00) begin
                  trap_next = 1'b1;
               end else begin
                  target_next = jump_target[PC_W-1:0];
                  state_next  = stall ? HOLD : ISSUE;
               end
            end
         end
         HOLD: begin
            if (!stall) state_next = ISSUE;
         end
         ISSUE: begin
            if (DRAIN_CYC > 0) begin
               state_next = DRAIN;
               drain_next = 3'(DRAIN_CYC);
            end else begin
               state_next = IDLE;
            end
         end
         DRAIN: begin
            // The drain window only counts cycles in which the front end actually advances.
            if (!stall) begin
               if (drain_reg <= 3'd1) begin
                  drain_next = 3'd0;
                  state_next = IDLE;
               end else begin
                  drain_next = drain_reg - 3'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (state_next == ISSUE && count_reg != {CNT_W{1'b1}}) begin
         count_next = count_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         drain_reg       <= 3'd0;
         target_reg      <= '0;
         count_reg       <= '0;
         pc_load_reg     <= 1'b0;
         flush_if_id_reg <= 1'b0;
         flush_id_ex_reg <= 1'b0;
         busy_reg        <= 1'b0;
         trap_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         drain_reg       <= drain_next;
         target_reg      <= target_next;
         count_reg       <= count_next;
         pc_load_reg     <= (state_next == ISSUE);
         flush_if_id_reg <= (state_next == ISSUE) || (state_next == DRAIN);
         flush_id_ex_reg <= (state_next == ISSUE);
         busy_reg        <= (state_next != IDLE);
         trap_reg        <= trap_next;
      end
   end

   assign pc_load         = pc_load_reg;
   assign pc_target       = target_reg;
   assign flush_if_id     = flush_if_id_reg;
   assign flush_id_ex     = flush_id_ex_reg;
   assign busy            = busy_reg;
   assign misaligned_trap = trap_reg;
   assign redirect_count  = count_reg;

endmodule

// File: tb/tb_redirect_controller.sv
// Directed bench for redirect_controller: default instance plus a 2-bit counter
// instance driven by the same stimulus to exercise counter saturation.
module tb_redirect_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        jump_valid;
   logic [31:0] jump_target;
   logic        stall;

   logic        pc_load, flush_if_id, flush_id_ex, busy, misaligned_trap;
   logic [8:0]  pc_target;
   logic [15:0] redirect_count;

   logic        s_pc_load, s_flush_if_id, s_flush_id_ex, s_busy, s_trap;
   logic [8:0]  s_pc_target;
   logic [1:0]  s_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   redirect_controller #(.PC_W(9), .DRAIN_CYC(1), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .jump_valid(jump_valid), .jump_target(jump_target),
      .stall(stall), .pc_load(pc_load), .pc_target(pc_target),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .busy(busy),
      .misaligned_trap(misaligned_trap), .redirect_count(redirect_count)
   );

   redirect_controller #(.PC_W(9), .DRAIN_CYC(1), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .jump_valid(jump_valid), .jump_target(jump_target),
      .stall(stall), .pc_load(s_pc_load), .pc_target(s_pc_target),
      .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex), .busy(s_busy),
      .misaligned_trap(s_trap), .redirect_count(s_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic pl, input logic [8:0] tgt,
                            input logic fif, input logic fie, input logic bsy,
                            input logic trp, input logic [15:0] cnt);
      chk({tag, ".pc_load"},         32'(pc_load),         32'(pl));
      chk({tag, ".pc_target"},       32'(pc_target),       32'(tgt));
      chk({tag, ".flush_if_id"},     32'(flush_if_id),     32'(fif));
      chk({tag, ".flush_id_ex"},     32'(flush_id_ex),     32'(fie));
      chk({tag, ".busy"},            32'(busy),            32'(bsy));
      chk({tag, ".misaligned_trap"}, 32'(misaligned_trap), 32'(trp));
      chk({tag, ".redirect_count"},  32'(redirect_count),  32'(cnt));
      $display("step %-12s pc_load=%0d pc_target=%h fif=%0d fie=%0d busy=%0d trap=%0d count=%0d sat_count=%0d",
               tag, pc_load, pc_target, flush_if_id, flush_id_ex, busy, misaligned_trap,
               redirect_count, s_count);
   endtask

   initial begin
      reset = 1'b1; jump_valid = 1'b0; jump_target = 32'h0; stall = 1'b0;
      step();
      step();
      check_all("reset", 0, 9'h000, 0, 0, 0, 0, 16'd0);
      chk("reset.sat_count", 32'(s_count), 32'd0);
      reset = 1'b0;
      step();
      check_all("idle", 0, 9'h000, 0, 0, 0, 0, 16'd0);

      // Basic redirect, no stall
      jump_valid = 1'b1; jump_target = 32'h0000_0040;
      step();
      jump_valid = 1'b0;
      check_all("t1.issue", 1, 9'h040, 1, 1, 1, 0, 16'd1);
      chk("t1.sat_count", 32'(s_count), 32'd1);
      step();
      check_all("t1.drain", 0, 9'h040, 1, 0, 1, 0, 16'd1);
      step();
      check_all("t1.idle", 0, 9'h040, 0, 0, 0, 0, 16'd1);

      // Redirect held by a three-cycle stall
      jump_valid = 1'b1; jump_target = 32'h0000_0080; stall = 1'b1;
      step();
      check_all("t2.hold1", 0, 9'h080, 0, 0, 1, 0, 16'd1);
      step();
      check_all("t2.hold2", 0, 9'h080, 0, 0, 1, 0, 16'd1);
      step();
      check_all("t2.hold3", 0, 9'h080, 0, 0, 1, 0, 16'd1);
      stall = 1'b0; jump_valid = 1'b0;
      step();
      check_all("t2.issue", 1, 9'h080, 1, 1, 1, 0, 16'd2);
      chk("t2.sat_count", 32'(s_count), 32'd2);
      step();
      check_all("t2.drain", 0, 9'h080, 1, 0, 1, 0, 16'd2);
      step();
      check_all("t2.idle", 0, 9'h080, 0, 0, 0, 0, 16'd2);

      // Misaligned target
      jump_valid = 1'b1; jump_target = 32'h0000_0042;
      step();
      jump_valid = 1'b0;
      check_all("t3.trap", 0, 9'h080, 0, 0, 0, 1, 16'd2);
      step();
      check_all("t3.after", 0, 9'h080, 0, 0, 0, 0, 16'd2);

      // Back-to-back requests: wrong-path ones in ISSUE and DRAIN are ignored
      jump_valid = 1'b1; jump_target = 32'h0000_0010;
      step();
      check_all("t4.issue10", 1, 9'h010, 1, 1, 1, 0, 16'd3);
      chk("t4.sat_count_a", 32'(s_count), 32'd3);
      jump_target = 32'h0000_0020;
      step();
      check_all("t4.drain20", 0, 9'h010, 1, 0, 1, 0, 16'd3);
      jump_target = 32'h0000_0030;
      step();
      check_all("t4.idle30", 0, 9'h010, 0, 0, 0, 0, 16'd3);
      jump_target = 32'h0000_0040;
      step();
      jump_valid = 1'b0;
      check_all("t4.issue40", 1, 9'h040, 1, 1, 1, 0, 16'd4);
      chk("t4.sat_count_b", 32'(s_count), 32'd3);
      step();
      step();
      check_all("t4.idle", 0, 9'h040, 0, 0, 0, 0, 16'd4);

      // Truncated target, stall during ISSUE and DRAIN (drain freezes)
      jump_valid = 1'b1; jump_target = 32'hFFFF_F204;
      step();
      jump_valid = 1'b0; stall = 1'b1;
      check_all("t5.issue", 1, 9'h004, 1, 1, 1, 0, 16'd5);
      chk("t5.sat_count", 32'(s_count), 32'd3);
      step();
      check_all("t5.drain_a", 0, 9'h004, 1, 0, 1, 0, 16'd5);
      step();
      check_all("t5.drain_b", 0, 9'h004, 1, 0, 1, 0, 16'd5);
      stall = 1'b0;
      step();
      check_all("t5.idle", 0, 9'h004, 0, 0, 0, 0, 16'd5);

      // Reset during HOLD discards the captured target
      jump_valid = 1'b1; jump_target = 32'h0000_0100; stall = 1'b1;
      step();
      check_all("t6.hold", 0, 9'h100, 0, 0, 1, 0, 16'd5);
      reset = 1'b1; jump_valid = 1'b0;
      step();
      check_all("t6.reset", 0, 9'h000, 0, 0, 0, 0, 16'd0);
      chk("t6.sat_count", 32'(s_count), 32'd0);
      reset = 1'b0; stall = 1'b0;
      step();
      check_all("t6.post1", 0, 9'h000, 0, 0, 0, 0, 16'd0);
      step();
      check_all("t6.post2", 0, 9'h000, 0, 0, 0, 0, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/redirect_controller.md
Name: redirect_controller

Overview:
Sequences control-flow redirects produced by the EX-stage jump/branch target logic in the pipelined RV32I core. It captures the resolved jump request and target, and waits out hazard-unit stalls. It then issues a one-cycle PC load plus pipeline flushes, and suppresses wrong-path jump requests during a programmable drain window. It also flags misaligned targets and keeps a saturating redirect counter for performance analysis.

Parameters:
PC_W, 9, width of the instruction-memory PC.
DRAIN_CYC, 1, number of cycles after ISSUE during which jump_valid is ignored and IF/ID is flushed (0..7).
CNT_W, 16, width of the redirect performance counter.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
jump_valid  input  1  EX stage resolved a taken jump/branch this cycle.
jump_target  input  32  resolved target address from the EX target logic.
stall  input  1  hazard-unit stall; freezes IF/ID/EX registers.
pc_load  output  1  one-cycle strobe: PC register loads pc_target. Has priority over stall at the PC mux.
pc_target  output  PC_W  redirect address, jump_target[PC_W-1:0] as captured.
flush_if_id  output  1  clear IF/ID pipeline register.
flush_id_ex  output  1  clear ID/EX pipeline register.
busy  output  1  high in any state other than IDLE.
misaligned_trap  output  1  one-cycle pulse: request had jump_target[1:0] != 0 and was dropped.
redirect_count  output  CNT_W  number of redirects issued, saturating.

Behaviour:
- All outputs are registered, driven from state and captured regs.
- Reset values: state=IDLE, pc_load=0, pc_target=0, flush_if_id=0, flush_id_ex=0, busy=0, misaligned_trap=0, redirect_count=0, drain counter=0.
- Reset wins over every simultaneous input. A reset mid-HOLD/ISSUE/DRAIN discards the captured target with no pc_load.
- States: IDLE, HOLD, ISSUE, DRAIN.
- IDLE:
  - jump_valid=1 and jump_target[1:0]!=0: next cycle misaligned_trap=1 for one cycle; stay IDLE; no load, no count.
  - jump_valid=1, aligned, stall=0: capture target; go to ISSUE.
  - jump_valid=1, aligned, stall=1: capture target; go to HOLD.
- HOLD:
  - busy=1; jump_valid ignored, because EX is frozen and the same request repeats.
  - Stays in HOLD while stall=1; goes to ISSUE on the first edge that samples stall=0.
- ISSUE:
  - Lasts exactly one cycle, regardless of stall.
  - Drives pc_load=1, flush_if_id=1, flush_id_ex=1.
  - redirect_count increments on entry to ISSUE and saturates at all ones.
  - Next state is DRAIN if DRAIN_CYC>0, with the drain counter loaded to DRAIN_CYC; otherwise IDLE.
- DRAIN:
  - Drives flush_if_id=1; flush_id_ex=0; jump_valid ignored (wrong-path).
  - Drain counter decrements only on cycles with stall=0 and freezes while stall=1.
  - Goes to IDLE when the counter reaches 0.
- Latency: a request accepted at edge N with stall=0 gives pc_load high in cycle N+1. Minimum spacing between two issued redirects is 2+DRAIN_CYC cycles.
- Target bits above PC_W are truncated silently. Alignment is checked on the full 32-bit value.

Test Plan:
- Reset, then jump_valid=1, target=0x0000_0040, stall=0 for one cycle -> the next cycle shows pc_load=1, pc_target=0x040, both flushes=1, count=1. The following cycle shows flush_if_id=1 only (DRAIN_CYC=1). IDLE after that.
- jump_valid=1, target=0x080, with stall=1 held 3 cycles -> busy=1 and no pc_load during the stall. pc_load=1 with pc_target=0x080 exactly one cycle after stall falls. count increments once.
- target=0x0000_0042 with jump_valid=1 -> misaligned_trap pulses 1 cycle, no pc_load, count unchanged, busy stays 0.
- jump_valid held high for 4 consecutive cycles with distinct targets 0x10, 0x20, 0x30, 0x40, stall=0 -> only 0x10 and 0x40 issue. 0x20 is ignored in ISSUE, 0x30 in DRAIN; 0x40 is re-accepted in IDLE.
- reset asserted during HOLD with target=0x100 -> the next cycle is IDLE with all outputs 0. No pc_load for 0x100 after reset is released.
- CNT_W=2: issue 5 aligned redirects -> redirect_count reads 1, 2, 3, 3, 3 (saturates, no wrap).
